// File: rtl/op_unit_exec.sv
// op_unit_exec: shift-add execution unit sequenced by microoperation strobes t1..t9
//   clk     rising-edge clock
//   res     asynchronous active-high reset
//   t1..t9  strobes: t1 A+=B, t2 CNT-- (sat 0), t3 A=din, t4 B=din, t5 A>>=1,
//           t6 B<<=1, t7 CNT=N_ITER, t8 A=0, t9 result=A and pulse done
//   din     load data for t3/t4
//   x       B[0]
//   y       CNT == 0
//   result  latched A
//   done    one-cycle pulse per t9 edge
//   ovf     sticky carry-out of the unshifted add
module op_unit_exec #(
    parameter int W      = 8,
    parameter int N_ITER = 8,
    parameter int CW     = 4
) (
    input  logic         clk,
    input  logic         res,
    input  logic         t1,
    input  logic         t2,
    input  logic         t3,
    input  logic         t4,
    input  logic         t5,
    input  logic         t6,
    input  logic         t7,
    input  logic         t8,
    input  logic         t9,
    input  logic [W-1:0] din,
    output logic         x,
    output logic         y,
    output logic [W-1:0] result,
    output logic         done,
    output logic         ovf
);
    logic [W-1:0]  a, b, a_nxt, b_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [W:0]    sum;
    logic          ovf_nxt;
    assign sum = {1'b0, a} + {1'b0, b};
    assign x   = b[0];
    assign y   = cnt == '0;
    always_comb begin
        a_nxt   = t3 ? din : t8 ? '0 : (t1 && t5) ? sum[W:1] : t1 ? sum[W-1:0] : t5 ? {1'b0, a[W-1:1]} : a;
        // carry only latches on the unshifted add; the shifted add keeps it in A's MSB
        ovf_nxt = (t3 || t8) ? 1'b0 : (t1 && !t5 && sum[W]) ? 1'b1 : ovf;
        b_nxt   = t4 ? din : t6 ? {b[W-2:0], 1'b0} : b;
        cnt_nxt = t7 ? CW'(N_ITER) : (t2 && cnt != '0) ? cnt - 1'b1 : cnt;
    end
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            a      <= '0;
            b      <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            a      <= a_nxt;
            b      <= b_nxt;
            cnt    <= cnt_nxt;
            ovf    <= ovf_nxt;
            result <= t9 ? a : result;
            done   <= t9;
        end
    end
endmodule

// File: tb/tb_op_unit_exec.sv
// tb_op_unit_exec: directed-vector bench for op_unit_exec
module tb_op_unit_exec;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic [9:1]   t = '0;
    logic [W-1:0] din = '0;
    logic         x, y, done, ovf;
    logic [W-1:0] result;
    int           vectors = 0;
    int           miscompares = 0;
    localparam logic [9:1] T1 = 9'b000000001, T2 = 9'b000000010, T3 = 9'b000000100,
                           T4 = 9'b000001000, T5 = 9'b000010000, T6 = 9'b000100000,
                           T7 = 9'b001000000, T8 = 9'b010000000, T9 = 9'b100000000;
    op_unit_exec #(.W(W), .N_ITER(8), .CW(4)) dut (
        .clk(clk), .res(res),
        .t1(t[1]), .t2(t[2]), .t3(t[3]), .t4(t[4]), .t5(t[5]),
        .t6(t[6]), .t7(t[7]), .t8(t[8]), .t9(t[9]),
        .din(din), .x(x), .y(y), .result(result), .done(done), .ovf(ovf)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic step(input logic [9:1] s, input logic [W-1:0] d);
        t   = s;
        din = d;
        @(posedge clk);
        #1;
        t = '0;
    endtask
    task automatic read_a(input string tag, input logic [W-1:0] exp);
        step(T9, '0);
        check(tag, result, exp);
        check({tag, "_done"}, done, 1);
    endtask
    int iters;
    logic [7:0] mult;
    initial begin
        #1;
        check("rst_x", x, 0);
        check("rst_y", y, 1);
        check("rst_result", result, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        @(posedge clk);
        #1;
        res = 1'b0;
        // load + flags
        step(T3 | T4, 8'h03);
        check("load_x", x, 1);
        check("load_done", done, 0);
        read_a("load_a", 8'h03);
        step(T7, '0);
        check("t7_y", y, 0);
        check("done_pulse", done, 0);
        // add-shift and plain add
        step(T3, 8'hF0);
        step(T4, 8'h20);
        step(T1 | T5, '0);
        check("addsh_ovf", ovf, 0);
        read_a("addsh_a", 8'h88);
        step(T3, 8'hF0);
        step(T1, '0);
        check("add_ovf", ovf, 1);
        read_a("add_a", 8'h10);
        step(T8, '0);
        check("clr_ovf", ovf, 0);
        read_a("clr_a", 8'h00);
        // counter saturation (CNT=8 from t7 above)
        for (int i = 0; i < 7; i++) step(T2, '0);
        check("cnt1_y", y, 0);
        for (int i = 0; i < 3; i++) begin
            step(T2, '0);
            check($sformatf("sat_y%0d", i), y, 1);
        end
        step(T7 | T2, '0);
        check("t7t2_y", y, 0);
        for (int i = 0; i < 7; i++) step(T2, '0);
        check("t7t2_cnt1_y", y, 0);
        step(T2, '0);
        check("t7t2_cnt0_y", y, 1);
        // priority
        step(T3 | T8 | T1 | T5, 8'h77);
        check("pri_a_ovf", ovf, 0);
        read_a("pri_a", 8'h77);
        step(T5, '0);
        read_a("shr_a", 8'h3B);
        step(T8 | T1 | T5, '0);
        read_a("pri_t8", 8'h00);
        step(T4 | T6, 8'h81);
        check("pri_b_x", x, 1);
        step(T1, '0);
        read_a("pri_b", 8'h81);
        step(T6, '0);
        check("shl_x", x, 0);
        step(T8, '0);
        step(T1, '0);
        read_a("shl_b", 8'h02);
        // 13 x 11: controller holds the multiplier, adds B on each set bit, shifts B
        mult = 8'd11;
        step(T8, '0);
        step(T4, 8'd13);
        check("mul_x", x, 1);
        step(T7, '0);
        iters = 0;
        while (!y && iters < 20) begin
            step((mult[iters[2:0]] ? T1 : 9'b0) | T6 | T2, '0);
            iters++;
        end
        check("mul_iters", iters, 8);
        step(T9, '0);
        check("mul_result", result, 143);
        check("mul_done", done, 1);
        check("mul_ovf", ovf, 0);
        step('0, '0);
        check("mul_done_end", done, 0);
        check("mul_hold", result, 143);
        // t9 samples pre-update A and re-latches while held
        step(T3, 8'h11);
        step(T9 | T3, 8'h22);
        check("t9_pre", result, 8'h11);
        step(T9, '0);
        check("t9_held", result, 8'h22);
        check("t9_held_done", done, 1);
        // async reset mid-run: A=0x5A, ovf=1, x=1, CNT=3, done high
        step(T4, 8'h69);
        step(T3, 8'hF1);
        step(T1, '0);
        check("pre_ovf", ovf, 1);
        step(T7, '0);
        for (int i = 0; i < 5; i++) step(T2, '0);
        check("pre_y", y, 0);
        t = T9;
        @(posedge clk);
        #1;
        check("pre_result", result, 8'h5A);
        check("pre_done", done, 1);
        #2 res = 1'b1;
        #1;
        check("ares_x", x, 0);
        check("ares_y", y, 1);
        check("ares_result", result, 0);
        check("ares_done", done, 0);
        check("ares_ovf", ovf, 0);
        t = '0;
        @(posedge clk);
        #1;
        res = 1'b0;
        read_a("post_rst_a", 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
